// File: rtl/ct_loader.sv
// Kyber512 ciphertext loader: gathers word-indexed AXI writes into one wide
// register and offers it to the decapsulation core over valid/ready.
// Optional build macro: CT_LOADER_ZEROIZE_EN (wipe o_ct_data on hand-off/clear).
module ct_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int CT_WORDS   = 192,
    parameter int CT_WIDTH   = WORD_WIDTH * CT_WORDS
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_clear,
    input  logic                  i_ct_ready,
    output logic                  o_ct_valid,
    output logic [CT_WIDTH-1:0]   o_ct_data,
    output logic [ADDR_WIDTH-1:0] o_words_loaded,
    output logic                  o_wr_err,
    output logic                  o_busy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state;
    logic [CT_WORDS-1:0]   written;
    logic [ADDR_WIDTH-1:0] count;
    logic [WORD_WIDTH-1:0] ct_mem [CT_WORDS];
    logic                  wr_err_p1;

    logic addr_ok;
    logic wr_accept;
    logic wr_reject;
    logic new_word;
    logic last_word;
    logic handshake;

    always_comb begin
        addr_ok   = int'(i_wr_addr) < CT_WORDS;
        wr_accept = i_wr_en && addr_ok && (state != ST_FULL);
        wr_reject = i_wr_en && !wr_accept;
        new_word  = 1'b0;
        if (wr_accept) begin
            new_word = !written[i_wr_addr];
        end
        last_word = new_word && (count == ADDR_WIDTH'(CT_WORDS - 1));
        handshake = (state == ST_FULL) && i_ct_ready;
    end

    // Control and data register stage; clear beats same-cycle writes and
    // suppresses their error pulse.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state     <= ST_EMPTY;
            written   <= '0;
            count     <= '0;
            wr_err_p1 <= 1'b0;
            for (int i = 0; i < CT_WORDS; i++) begin
                ct_mem[i] <= '0;
            end
        end else begin
            wr_err_p1 <= wr_reject && !i_clear;
            if (i_clear || handshake) begin
                state   <= ST_EMPTY;
                written <= '0;
                count   <= '0;
`ifdef CT_LOADER_ZEROIZE_EN
                for (int i = 0; i < CT_WORDS; i++) begin
                    ct_mem[i] <= '0;
                end
`endif
            end else if (wr_accept) begin
                ct_mem[i_wr_addr]  <= i_wr_data;
                written[i_wr_addr] <= 1'b1;
                if (new_word) begin
                    count <= count + ADDR_WIDTH'(1);
                end
                if (last_word) begin
                    state <= ST_FULL;
                end else if (state == ST_EMPTY) begin
                    state <= ST_FILL;
                end
            end
        end
    end

    // Word 0 lands in the most significant slice.
    for (genvar g = 0; g < CT_WORDS; g++) begin : g_pack
        assign o_ct_data[CT_WIDTH-1-WORD_WIDTH*g -: WORD_WIDTH] = ct_mem[g];
    end

    assign o_ct_valid     = (state == ST_FULL);
    assign o_busy         = (state != ST_EMPTY);
    assign o_words_loaded = count;
    assign o_wr_err       = wr_err_p1;

endmodule

// File: tb/tb_ct_loader.sv
// Scoreboard bench for ct_loader: stimulus queues expected ciphertexts and
// error pulses, a negedge monitor checks them as the DUT presents them.
module tb_ct_loader;

    localparam int ADDR_WIDTH = 8;
    localparam int WORD_WIDTH = 32;
    localparam int CT_WORDS   = 192;
    localparam int CT_WIDTH   = WORD_WIDTH * CT_WORDS;

    logic                  clk;
    logic                  resetn;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  clear;
    logic                  ct_ready;
    logic                  ct_valid;
    logic [CT_WIDTH-1:0]   ct_data;
    logic [ADDR_WIDTH-1:0] words_loaded;
    logic                  wr_err;
    logic                  busy;

    ct_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .WORD_WIDTH(WORD_WIDTH),
        .CT_WORDS  (CT_WORDS)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_clear       (clear),
        .i_ct_ready    (ct_ready),
        .o_ct_valid    (ct_valid),
        .o_ct_data     (ct_data),
        .o_words_loaded(words_loaded),
        .o_wr_err      (wr_err),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [CT_WIDTH-1:0] model_ct;
    logic [CT_WIDTH-1:0] ct_q [$];
    int                  err_q [$];
    logic [CT_WIDTH-1:0] cur_exp;
    logic                prev_valid = 1'b0;

    function automatic logic [WORD_WIDTH-1:0] word_of(input logic [CT_WIDTH-1:0] v, input int i);
        return v[CT_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_ct(input string nm, input logic [CT_WIDTH-1:0] exp);
        compared++;
        if (ct_data !== exp) begin
            mismatched++;
            for (int i = 0; i < CT_WORDS; i++) begin
                if (word_of(ct_data, i) !== word_of(exp, i)) begin
                    $display("FAIL %s: word %0d got 0x%08h expected 0x%08h",
                             nm, i, word_of(ct_data, i), word_of(exp, i));
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_WIDTH'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Golden model bookkeeping for hand-offs and clears.
    task automatic model_drop();
`ifdef CT_LOADER_ZEROIZE_EN
        model_ct = '0;
`endif
    endtask

    task automatic handshake();
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        model_drop();
    endtask

    // Monitor: checks each presented ciphertext and every error pulse.
    always @(negedge clk) begin
        if (ct_valid === 1'b1) begin
            if (!prev_valid) begin
                if (ct_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_valid: got 1 expected 0");
                end else begin
                    cur_exp = ct_q.pop_front();
                end
            end
            chk_ct("ct_data", cur_exp);
        end
        if (wr_err === 1'b1) begin
            compared++;
            if (err_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_wr_err: got 1 expected 0");
            end else begin
                void'(err_q.pop_front());
            end
        end
        prev_valid = (ct_valid === 1'b1);
    end

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clear = 1'b0; ct_ready = 1'b0;
        model_ct = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_valid", 32'(ct_valid), 0);
        chk("rst_words", 32'(words_loaded), 0);
        chk("rst_err", 32'(wr_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk_ct("rst_data", '0);
        resetn = 1'b1;

        // Ascending load, data = index
        for (int i = 0; i < CT_WORDS; i++) begin
            model_ct[CT_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH] = 32'(i);
            if (i == CT_WORDS - 1) ct_q.push_back(model_ct);
            wr(i, 32'(i));
            if (i == CT_WORDS - 2) begin
                @(negedge clk);
                chk("asc_valid_early", 32'(ct_valid), 0);
                chk("asc_words_191", 32'(words_loaded), 191);
            end
        end
        @(negedge clk);
        chk("asc_valid", 32'(ct_valid), 1);
        chk("asc_words", 32'(words_loaded), 192);
        chk("asc_top", ct_data[6143:6112], 32'h0);
        chk("asc_low", ct_data[31:0], 32'hBF);

        // Rejected write while FULL
        err_q.push_back(1);
        wr(3, 32'hDEADBEEF);
        @(negedge clk);
        chk("full_word3", word_of(ct_data, 3), 32'h3);
        chk("full_words", 32'(words_loaded), 192);

        // Backpressure then hand-off
        repeat (10) tick();
        @(negedge clk);
        chk("hold_valid", 32'(ct_valid), 1);
        handshake();
        @(negedge clk);
        chk("xfer_valid", 32'(ct_valid), 0);
        chk("xfer_words", 32'(words_loaded), 0);
        chk("xfer_busy", 32'(busy), 0);
        chk_ct("xfer_data", model_ct);

        // Descending load with a rewrite of index 5 and an out-of-range write
        for (int a = CT_WORDS - 1; a >= 6; a--) begin
            model_ct[CT_WIDTH-1-WORD_WIDTH*a -: WORD_WIDTH] = 32'h100 + 32'(a);
            wr(a, 32'h100 + 32'(a));
            if (a == 100) begin
                err_q.push_back(1);
                wr(200, 32'h0BAD0BAD);
                @(negedge clk);
                chk("oor_words", 32'(words_loaded), 92);
                chk("oor_busy", 32'(busy), 1);
            end
        end
        wr(5, 32'h11);
        for (int a = 4; a >= 1; a--) begin
            model_ct[CT_WIDTH-1-WORD_WIDTH*a -: WORD_WIDTH] = 32'h100 + 32'(a);
            wr(a, 32'h100 + 32'(a));
        end
        wr(5, 32'h22);
        model_ct[CT_WIDTH-1-WORD_WIDTH*5 -: WORD_WIDTH] = 32'h22;
        @(negedge clk);
        chk("desc_valid_early", 32'(ct_valid), 0);
        chk("desc_words_191", 32'(words_loaded), 191);
        model_ct[CT_WIDTH-1 -: WORD_WIDTH] = 32'h100;
        ct_q.push_back(model_ct);
        wr(0, 32'h100);
        @(negedge clk);
        chk("desc_valid", 32'(ct_valid), 1);
        chk("desc_word5", word_of(ct_data, 5), 32'h22);
        handshake();
        @(negedge clk);
        chk("desc_xfer_valid", 32'(ct_valid), 0);

        // Partial load then clear with a same-cycle write
        for (int i = 0; i < 100; i++) begin
            model_ct[CT_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH] = 32'hA000_0000 | 32'(i);
            wr(i, 32'hA000_0000 | 32'(i));
        end
        @(negedge clk);
        chk("part_words", 32'(words_loaded), 100);
        clear = 1'b1;
        wr(100, 32'h5555_5555);
        clear = 1'b0;
        model_drop();
        @(negedge clk);
        chk("clr_words", 32'(words_loaded), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_valid", 32'(ct_valid), 0);
        chk_ct("clr_data", model_ct);
        tick();
        @(negedge clk);
        chk("clr_no_err", 32'(wr_err), 0);

        // Reset mid-fill, then a clean full load with ready held high
        for (int i = 0; i < 50; i++) wr(i, 32'h5000_0000 + 32'(i));
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_valid", 32'(ct_valid), 0);
        chk("mid_rst_words", 32'(words_loaded), 0);
        chk("mid_rst_err", 32'(wr_err), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk_ct("mid_rst_data", '0);
        model_ct = '0;
        resetn = 1'b1;
        ct_ready = 1'b1;
        for (int i = 0; i < CT_WORDS; i++) begin
            model_ct[CT_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH] = ~32'(i);
            if (i == CT_WORDS - 1) ct_q.push_back(model_ct);
            wr(i, ~32'(i));
        end
        @(negedge clk);
        chk("final_valid", 32'(ct_valid), 1);
        tick();
        ct_ready = 1'b0;
        @(negedge clk);
        chk("final_xfer_valid", 32'(ct_valid), 0);
        chk("final_words", 32'(words_loaded), 0);

        repeat (3) tick();
        chk("ct_q_drained", 32'(ct_q.size()), 0);
        chk("err_q_drained", 32'(err_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ct_loader.md
Name: ct_loader

Overview:
- Upstream counterpart to the ciphertext output splitter.
- Collects a Kyber512 ciphertext written as 32-bit words from the AXI slave register interface, addressed by word index.
- Assembles the words into one wide ciphertext register.
- Hands the register to the decapsulation core with a valid/ready handshake, then re-arms for the next ciphertext.

Parameters:
ADDR_WIDTH, 8, width of word-index address
WORD_WIDTH, 32, width of one AXI data word
CT_WORDS, 192, words per ciphertext (768 bytes)
CT_WIDTH, WORD_WIDTH*CT_WORDS (6144), width of assembled ciphertext bus

Ports:
i_clk  input  1  clock
i_resetn  input  1  synchronous active-low reset
i_wr_en  input  1  word write strobe, one word per cycle
i_wr_addr  input  ADDR_WIDTH  word index 0..CT_WORDS-1
i_wr_data  input  WORD_WIDTH  word data
i_clear  input  1  synchronous abort; discard partial or held ciphertext
i_ct_ready  input  1  core accepts ciphertext
o_ct_valid  output  1  assembled ciphertext available
o_ct_data  output  CT_WIDTH  assembled ciphertext, MSB-first
o_words_loaded  output  ADDR_WIDTH  count of distinct words written
o_wr_err  output  1  one-cycle pulse on a rejected write
o_busy  output  1  high in FILL or FULL

Behaviour:
- Reset (i_resetn=0 at posedge):
  - state=EMPTY; written bitmap cleared.
  - o_ct_valid=0, o_words_loaded=0, o_wr_err=0, o_busy=0, o_ct_data=0.
- Packing: word at index a occupies o_ct_data[CT_WIDTH-1-WORD_WIDTH*a -: WORD_WIDTH]. Word 0 is the most significant.
- Written bitmap: one bit per word. o_words_loaded counts set bits.
- States:
  - EMPTY: the first accepted write goes to FILL.
  - FILL: accepts writes. When a write sets the last unset bit, go to FULL.
  - FULL: o_ct_valid=1. On o_ct_valid&&i_ct_ready, go to EMPTY.
- Accepted write (i_wr_en=1, i_wr_addr<CT_WORDS, state EMPTY or FILL):
  - Data is stored and the bit is set at the next edge.
  - A rewrite of an already-set index overwrites the data. The count does not change.
- Latency: the write that completes the set at edge t raises o_ct_valid after edge t. o_words_loaded=CT_WORDS in the same cycle.
- Rejected write: i_wr_en=1 with i_wr_addr>=CT_WORDS, or i_wr_en=1 in FULL.
  - No state or data change.
  - o_wr_err=1 for exactly the following cycle.
- Handshake:
  - While o_ct_valid=1, o_ct_data is stable.
  - o_ct_valid never drops without a transfer, i_clear or reset.
  - On transfer: bitmap cleared, o_words_loaded=0, state EMPTY, o_ct_valid=0 after that edge.
- i_clear:
  - Acts the same as a transfer in every state: bitmap cleared, state EMPTY, o_ct_valid=0.
  - Takes priority over a same-cycle i_wr_en; that write is dropped and no o_wr_err is raised.
- Simultaneous i_clear and handshake: the transfer is counted as completed and the state goes to EMPTY.
- Reset mid-FILL or mid-FULL: all progress is discarded, and outputs take their reset values.
- o_busy = (state != EMPTY).

Optional Feature:
- Macro: CT_LOADER_ZEROIZE_EN.
- Defined: on a transfer or i_clear, o_ct_data is zeroed at the same edge, so no ciphertext residue remains after hand-off.
- Undefined: o_ct_data holds its last contents until overwritten. Only the bitmap and count are cleared.

Test Plan:
- Reset, then write words 0..191 with data=index (0x00000000..0x000000BF), i_ct_ready=0 → o_ct_valid=1 the cycle after the write of 191; o_ct_data[6143:6112]=0x0, o_ct_data[31:0]=0xBF; o_words_loaded=192.
- Write all 192 words out of order (descending), with index 5 written twice (0x11 then 0x22) → o_ct_valid rises only after the 192nd distinct index; word 5 reads 0x22.
- In FULL, write index 3 data 0xDEADBEEF → o_wr_err pulses 1 cycle; word 3 unchanged. Write index 200 in FILL → o_wr_err pulse, count unchanged.
- Hold i_ct_ready=0 for 10 cycles in FULL, then assert it → o_ct_valid and o_ct_data stable for 10 cycles; after the handshake, o_ct_valid=0, o_words_loaded=0, o_busy=0.
- Load 100 words, pulse i_clear together with a write → o_words_loaded=0, state EMPTY, no o_wr_err. With CT_LOADER_ZEROIZE_EN, o_ct_data=0; without it, the first 100 words are retained.
- Load 50 words, assert i_resetn=0 for 1 cycle → all outputs at reset values; a subsequent full load completes normally.
